// File: rtl/ewb_queue.sv
// Eviction write buffer: DEPTH-entry circular queue of dirty lines between the
// cache evict path and pmem, with write coalescing and read hits from the buffer.
module ewb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              empty,
    output logic              full
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_PMEM_READ,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [IDX_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] rdata_q;

    logic              match_hit;
    logic [IDX_W-1:0]  match_idx;
    logic              do_alloc, do_coal, do_pop, load_hit, load_pmem;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Coalescing keeps addresses unique, so at most one entry can match.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == mem_address)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d      = state_q;
        do_alloc     = 1'b0;
        do_coal      = 1'b0;
        do_pop       = 1'b0;
        load_hit     = 1'b0;
        load_pmem    = 1'b0;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            S_IDLE: begin
                if (mem_write) begin
                    if (match_hit) begin
                        do_coal = 1'b1;
                        state_d = S_RESP;
                    end else if (!full) begin
                        do_alloc = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (mem_read) begin
                    if (match_hit) begin
                        load_hit = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_PMEM_READ;
                    end
                end else if (!empty) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = addr_q[head_q];
                pmem_wdata   = data_q[head_q];
                if (pmem_resp) begin
                    do_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PMEM_READ: begin
                pmem_read    = 1'b1;
                pmem_address = mem_address;
                if (pmem_resp) begin
                    load_pmem = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                mem_resp  = 1'b1;
                mem_rdata = rdata_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, queue storage and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (do_coal) begin
                data_q[match_idx] <= mem_wdata;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= mem_address;
                data_q[tail_q]  <= mem_wdata;
                tail_q          <= ptr_inc(tail_q);
                count_q         <= count_q + 1'b1;
            end else if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
                count_q         <= count_q - 1'b1;
            end
            if (load_hit) begin
                rdata_q <= data_q[match_idx];
            end else if (load_pmem) begin
                rdata_q <= pmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ewb_queue.sv
// Cycle-by-cycle vector bench for ewb_queue: each record gives the inputs for
// one cycle and the outputs expected during that same cycle.
module tb_ewb_queue;

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0]  addr;
        logic [255:0] wdata, prdata;
        logic        presp;
        logic        e_resp, chk_rd;
        logic [255:0] e_rdata;
        logic        e_pr, e_pw;
        logic [31:0]  e_paddr;
        logic [255:0] e_pwdata;
        logic        e_empty, e_full;
    } vec_t;

    localparam logic [255:0] D1    = {8{32'h1111_0001}};
    localparam logic [255:0] D2    = {8{32'h2222_0002}};
    localparam logic [255:0] D3    = {8{32'h3333_0003}};
    localparam logic [255:0] D5    = {8{32'h5555_0005}};
    localparam logic [255:0] DDEAD = {8{32'hDEAD_C0DE}};
    localparam logic [255:0] DBEEF = {8{32'hBEEF_F00D}};

    logic         clk = 1'b0;
    logic         rst, mem_read, mem_write, pmem_resp;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata, pmem_rdata;
    logic [255:0] mem_rdata, pmem_wdata;
    logic         mem_resp, pmem_read, pmem_write, empty, full;
    logic [31:0]  pmem_address;

    int nvec = 0;
    int nerr = 0;
    logic bad;

    ewb_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(256)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, rd, wr, input logic [31:0] a,
                                input logic [255:0] wd, pr, input logic presp,
                                input logic eresp, chk, input logic [255:0] erd,
                                input logic epr, epw, input logic [31:0] epa,
                                input logic [255:0] epwd, input logic eem, efu);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.prdata = pr;
        v.presp = presp; v.e_resp = eresp; v.chk_rd = chk; v.e_rdata = erd;
        v.e_pr = epr; v.e_pw = epw; v.e_paddr = epa; v.e_pwdata = epwd;
        v.e_empty = eem; v.e_full = efu;
        return v;
    endfunction

    // IDLE cycle: no request/response outputs expected.
    function automatic vec_t idle_row(input logic rd, wr, input logic [31:0] a,
                                      input logic [255:0] wd, input logic em, fu);
        return mk(1'b0, rd, wr, a, wd, '0, 1'b0, 1'b0, 1'b0, '0,
                  1'b0, 1'b0, '0, '0, em, fu);
    endfunction

    function automatic vec_t resp_row(input logic rd, wr, input logic [31:0] a,
                                      input logic [255:0] wd, input logic chk,
                                      input logic [255:0] erd, input logic em, fu);
        return mk(1'b0, rd, wr, a, wd, '0, 1'b0, 1'b1, chk, erd,
                  1'b0, 1'b0, '0, '0, em, fu);
    endfunction

    function automatic vec_t drain_row(input logic presp, input logic [31:0] pa,
                                       input logic [255:0] pwd, input logic em, fu,
                                       input logic wr, input logic [31:0] a,
                                       input logic [255:0] wd);
        return mk(1'b0, 1'b0, wr, a, wd, '0, presp, 1'b0, 1'b0, '0,
                  1'b0, 1'b1, pa, pwd, em, fu);
    endfunction

    function automatic vec_t pread_row(input logic [31:0] a, input logic presp,
                                       input logic [255:0] pr);
        return mk(1'b0, 1'b1, 1'b0, a, '0, pr, presp, 1'b0, 1'b0, '0,
                  1'b1, 1'b0, a, '0, 1'b1, 1'b0);
    endfunction

    task automatic cmp(input string nm, input logic [255:0] got, exp);
        if (got !== exp) begin
            $display("FAIL vec %0d %s: got %h want %h", nvec, nm, got, exp);
            bad = 1'b1;
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check before the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; mem_read = v.rd; mem_write = v.wr; mem_address = v.addr;
        mem_wdata = v.wdata; pmem_rdata = v.prdata; pmem_resp = v.presp;
        #1;
        bad = 1'b0;
        cmp("mem_resp", 256'(mem_resp), 256'(v.e_resp));
        if (!v.e_resp || v.chk_rd) cmp("mem_rdata", mem_rdata, v.e_rdata);
        cmp("pmem_read", 256'(pmem_read), 256'(v.e_pr));
        cmp("pmem_write", 256'(pmem_write), 256'(v.e_pw));
        cmp("pmem_address", 256'(pmem_address), 256'(v.e_paddr));
        cmp("pmem_wdata", pmem_wdata, v.e_pwdata);
        cmp("empty", 256'(empty), 256'(v.e_empty));
        cmp("full", 256'(full), 256'(v.e_full));
        nvec++;
        if (bad) nerr++;
    endtask

    vec_t tbl[$];
    logic [31:0]  fa [5];
    logic [255:0] fd [5];

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
        mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then single write and its drain.
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b1, 32'h100, D1, 1'b1, 1'b0));
        tbl.push_back(resp_row(1'b0, 1'b1, 32'h100, D1, 1'b0, '0, 1'b0, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
        tbl.push_back(drain_row(1'b0, 32'h100, D1, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(drain_row(1'b1, 32'h100, D1, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        // Coalesce: second write to same line replaces data, drained once.
        tbl.push_back(idle_row(1'b0, 1'b1, 32'h100, D1, 1'b1, 1'b0));
        tbl.push_back(resp_row(1'b0, 1'b1, 32'h100, D1, 1'b0, '0, 1'b0, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b1, 32'h100, D2, 1'b0, 1'b0));
        tbl.push_back(resp_row(1'b0, 1'b1, 32'h100, D2, 1'b0, '0, 1'b0, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
        tbl.push_back(drain_row(1'b0, 32'h100, D2, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(drain_row(1'b0, 32'h100, D2, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(drain_row(1'b1, 32'h100, D2, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        // Read hit returns buffered data without touching pmem.
        tbl.push_back(idle_row(1'b0, 1'b1, 32'h040, DDEAD, 1'b1, 1'b0));
        tbl.push_back(resp_row(1'b0, 1'b1, 32'h040, DDEAD, 1'b0, '0, 1'b0, 1'b0));
        tbl.push_back(idle_row(1'b1, 1'b0, 32'h040, '0, 1'b0, 1'b0));
        tbl.push_back(resp_row(1'b1, 1'b0, 32'h040, '0, 1'b1, DDEAD, 1'b0, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
        tbl.push_back(drain_row(1'b1, 32'h040, DDEAD, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        // Read miss with a 3-cycle pmem read.
        tbl.push_back(idle_row(1'b1, 1'b0, 32'h200, '0, 1'b1, 1'b0));
        tbl.push_back(pread_row(32'h200, 1'b0, '0));
        tbl.push_back(pread_row(32'h200, 1'b0, '0));
        tbl.push_back(pread_row(32'h200, 1'b1, DBEEF));
        tbl.push_back(resp_row(1'b1, 1'b0, 32'h200, '0, 1'b1, DBEEF, 1'b1, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        // Read and write together: the write wins and allocates.
        tbl.push_back(idle_row(1'b1, 1'b1, 32'h300, D3, 1'b1, 1'b0));
        tbl.push_back(resp_row(1'b1, 1'b1, 32'h300, D3, 1'b0, '0, 1'b0, 1'b0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
        tbl.push_back(drain_row(1'b1, 32'h300, D3, 1'b0, 1'b0, 1'b0, '0, '0));
        tbl.push_back(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));

        foreach (tbl[k]) apply(tbl[k]);

        // Fill to full, then a 5th write forces one stalled drain before accept.
        for (int i = 0; i < 5; i++) begin
            fa[i] = 32'(i * 32'h20);
            fd[i] = {8{32'(32'hA000_0000 + i)}};
        end
        fd[4] = D5;
        for (int i = 0; i < 4; i++) begin
            apply(idle_row(1'b0, 1'b1, fa[i], fd[i], i == 0, 1'b0));
            apply(resp_row(1'b0, 1'b1, fa[i], fd[i], 1'b0, '0, 1'b0, i == 3));
        end
        apply(idle_row(1'b0, 1'b1, fa[4], fd[4], 1'b0, 1'b1));
        for (int k = 0; k < 10; k++)
            apply(drain_row(1'b0, fa[0], fd[0], 1'b0, 1'b1, 1'b1, fa[4], fd[4]));
        apply(drain_row(1'b1, fa[0], fd[0], 1'b0, 1'b1, 1'b1, fa[4], fd[4]));
        apply(idle_row(1'b0, 1'b1, fa[4], fd[4], 1'b0, 1'b0));
        apply(resp_row(1'b0, 1'b1, fa[4], fd[4], 1'b0, '0, 1'b0, 1'b1));
        for (int j = 1; j < 5; j++) begin
            apply(idle_row(1'b0, 1'b0, '0, '0, 1'b0, j == 1));
            apply(drain_row(1'b1, fa[j], fd[j], 1'b0, j == 1, 1'b0, '0, '0));
        end
        apply(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));

        // Reset during DRAIN abandons the writeback and clears the queue.
        apply(idle_row(1'b0, 1'b1, 32'h500, D1, 1'b1, 1'b0));
        apply(resp_row(1'b0, 1'b1, 32'h500, D1, 1'b0, '0, 1'b0, 1'b0));
        apply(idle_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
        apply(drain_row(1'b0, 32'h500, D1, 1'b0, 1'b0, 1'b0, '0, '0));
        apply(mk(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0,
                 1'b0, 1'b1, 32'h500, D1, 1'b0, 1'b0));
        apply(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        apply(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));

        // Reset during PMEM_READ drops pmem_read next cycle.
        apply(idle_row(1'b1, 1'b0, 32'h200, '0, 1'b1, 1'b0));
        apply(pread_row(32'h200, 1'b0, '0));
        apply(mk(1'b1, 1'b1, 1'b0, 32'h200, '0, '0, 1'b0, 1'b0, 1'b0, '0,
                 1'b1, 1'b0, 32'h200, '0, 1'b1, 1'b0));
        apply(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));
        apply(idle_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
